// File: rtl/psk8_slicer.sv
// 8-PSK hard-decision slicer: 3-stage pipeline (abs/sector, de-rotation, output).
// Define PSK8_SLICER_DIST_EN to add the dist port and its L1 distance logic.
module psk8_slicer #(
  parameter int WIDTH = 20,
  parameter int AMP   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] y_real,
  input  logic signed [WIDTH-1:0] y_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              s_hat,
  output logic signed [WIDTH-1:0] res_real,
  output logic signed [WIDTH-1:0] res_imag
`ifdef PSK8_SLICER_DIST_EN
  ,
  output logic [WIDTH:0]          dist
`endif
);

  localparam logic [WIDTH+8:0]         MUL106 = (WIDTH+9)'(106);
  localparam logic signed [WIDTH+10:0] K181   = (WIDTH+11)'(181);
  localparam logic signed [WIDTH+10:0] SMAX   = {12'd0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+10:0] SMIN   = {{12{1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] v);
    if (v == {1'b1, {(WIDTH-1){1'b0}}})
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v[WIDTH-1])
      return -v;
    else
      return v;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH+10:0] v);
    if (v > SMAX)
      return SMAX[WIDTH-1:0];
    else if (v < SMIN)
      return SMIN[WIDTH-1:0];
    else
      return v[WIDTH-1:0];
  endfunction

  // Angle index to the symbol code used by the rotation multiplier.
  function automatic logic [2:0] map_k(input logic [2:0] k);
    case (k)
      3'd0:    return 3'd7;
      3'd1:    return 3'd6;
      3'd2:    return 3'd2;
      3'd3:    return 3'd3;
      3'd4:    return 3'd1;
      3'd5:    return 3'd0;
      3'd6:    return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  logic                    en;
  logic                    s1_valid_reg, s2_valid_reg, out_valid_reg;
  logic signed [WIDTH-1:0] s1_re_reg, s1_im_reg;
  logic [2:0]              s1_k_reg;
  logic signed [WIDTH-1:0] s2_re_reg, s2_im_reg;
  logic [2:0]              s2_s_hat_reg;
  logic [2:0]              s_hat_reg;
  logic signed [WIDTH-1:0] res_re_reg, res_im_reg;

  assign en        = !(out_valid_reg && !out_ready);
  assign in_ready  = en;
  assign out_valid = out_valid_reg;
  assign s_hat     = s_hat_reg;
  assign res_real  = res_re_reg;
  assign res_imag  = res_im_reg;

  // Stage 1: magnitudes and sector decision
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH+8:0] a_ext, b_ext, a_256, b_256, a_106, b_106;
  logic [2:0]       k_next;
  logic             re_neg, im_neg;

  always_comb begin
    a_abs  = abs_sat(y_real);
    b_abs  = abs_sat(y_imag);
    a_ext  = {9'd0, a_abs};
    b_ext  = {9'd0, b_abs};
    a_256  = a_ext << 8;
    b_256  = b_ext << 8;
    a_106  = a_ext * MUL106;
    b_106  = b_ext * MUL106;
    re_neg = y_real[WIDTH-1];
    im_neg = y_imag[WIDTH-1];
    k_next = 3'd0;
    if (b_256 <= a_106)
      k_next = re_neg ? 3'd4 : 3'd0;
    else if (a_256 <= b_106)
      k_next = im_neg ? 3'd6 : 3'd2;
    else begin
      case ({re_neg, im_neg})
        2'b00:   k_next = 3'd1;
        2'b10:   k_next = 3'd3;
        2'b11:   k_next = 3'd5;
        default: k_next = 3'd7;
      endcase
    end
  end

  // Stage 2: y * conj(symbol); odd k are diagonals scaled by 181/256
  logic signed [WIDTH+1:0]  re_x, im_x, p_re, p_im;
  logic signed [WIDTH+10:0] pw_re, pw_im, q_re, q_im;

  always_comb begin
    re_x = s1_re_reg;
    im_x = s1_im_reg;
    p_re = re_x;
    p_im = im_x;
    case (s1_k_reg)
      3'd0: begin p_re = re_x;         p_im = im_x;         end
      3'd1: begin p_re = re_x + im_x;  p_im = im_x - re_x;  end
      3'd2: begin p_re = im_x;         p_im = -re_x;        end
      3'd3: begin p_re = im_x - re_x;  p_im = -im_x - re_x; end
      3'd4: begin p_re = -re_x;        p_im = -im_x;        end
      3'd5: begin p_re = -re_x - im_x; p_im = re_x - im_x;  end
      3'd6: begin p_re = -im_x;        p_im = re_x;         end
      default: begin p_re = re_x - im_x; p_im = im_x + re_x; end
    endcase
    pw_re = p_re;
    pw_im = p_im;
    if (s1_k_reg[0]) begin
      q_re = (pw_re * K181) >>> 8;
      q_im = (pw_im * K181) >>> 8;
    end else begin
      q_re = pw_re;
      q_im = pw_im;
    end
  end

`ifdef PSK8_SLICER_DIST_EN
  // Stage 3 distance: |res_real - AMP| + |res_imag|
  localparam logic signed [WIDTH+2:0] AMP_X = (WIDTH+3)'(AMP);
  logic signed [WIDTH+2:0] d_re, d_im;
  logic [WIDTH+2:0]        d_abs_re, d_abs_im, d_sum;
  logic [WIDTH:0]          dist_next;
  logic [WIDTH:0]          dist_reg;

  always_comb begin
    d_re      = s2_re_reg;
    d_re      = d_re - AMP_X;
    d_im      = s2_im_reg;
    d_abs_re  = d_re[WIDTH+2] ? -d_re : d_re;
    d_abs_im  = d_im[WIDTH+2] ? -d_im : d_im;
    d_sum     = d_abs_re + d_abs_im;
    dist_next = (d_sum[WIDTH+2:WIDTH+1] != 2'b00) ? {(WIDTH+1){1'b1}} : d_sum[WIDTH:0];
  end

  assign dist = dist_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      s_hat_reg     <= 3'd0;
      res_re_reg    <= '0;
      res_im_reg    <= '0;
`ifdef PSK8_SLICER_DIST_EN
      dist_reg      <= '0;
`endif
    end else if (en) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_re_reg <= y_real;
        s1_im_reg <= y_imag;
        s1_k_reg  <= k_next;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_re_reg    <= sat_w(q_re);
        s2_im_reg    <= sat_w(q_im);
        s2_s_hat_reg <= map_k(s1_k_reg);
      end
      out_valid_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        s_hat_reg  <= s2_s_hat_reg;
        res_re_reg <= s2_re_reg;
        res_im_reg <= s2_im_reg;
`ifdef PSK8_SLICER_DIST_EN
        dist_reg   <= dist_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_psk8_slicer.sv
// Directed self-checking bench for psk8_slicer (WIDTH=20, AMP=1024).
module tb_psk8_slicer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] y_real, y_imag;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         s_hat;
  logic signed [19:0] res_real, res_imag;
`ifdef PSK8_SLICER_DIST_EN
  logic [20:0]        dist;
`endif

  int checks = 0;
  int failures = 0;

  psk8_slicer #(.WIDTH(20), .AMP(1024)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y_real(y_real),
    .y_imag(y_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s_hat(s_hat),
    .res_real(res_real),
    .res_imag(res_imag)
`ifdef PSK8_SLICER_DIST_EN
    ,
    .dist(dist)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated sample: out_valid must stay low until exactly 3 edges after acceptance.
  task automatic run_one(input string name, input int yr, input int yi,
                         input int e_s, input int e_rr, input int e_ri, input int e_d);
    in_valid = 1'b1;
    y_real   = 20'(yr);
    y_imag   = 20'(yi);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({name, "_early_valid"}, out_valid, 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_s_hat"}, s_hat, e_s);
    chk({name, "_res_real"}, res_real, e_rr);
    chk({name, "_res_imag"}, res_imag, e_ri);
`ifdef PSK8_SLICER_DIST_EN
    chk({name, "_dist"}, dist, e_d);
`endif
    $display("txn %s y=(%0d,%0d) s_hat=%0d res=(%0d,%0d) exp_dist=%0d",
             name, yr, yi, s_hat, res_real, res_imag, e_d);
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, recv, stall;
    logic acc, cons;
    logic signed [19:0] hold_re;
    logic [2:0] hold_s;

    rst = 1'b1; in_valid = 1'b0; y_real = '0; y_imag = '0; out_ready = 1'b1;
    hold_re = '0; hold_s = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_s_hat", s_hat, 0);
    chk("reset_res_real", res_real, 0);
    chk("reset_res_imag", res_imag, 0);
`ifdef PSK8_SLICER_DIST_EN
    chk("reset_dist", dist, 0);
`endif
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);

    run_one("k0_axis",   1024,     0, 7, 1024,    0,      0);
    run_one("k1_diag",    724,   724, 6, 1023,    0,      1);
    run_one("k6_axis",      0, -1024, 4, 1024,    0,      0);
    run_one("k4_axis",  -1024,     0, 1, 1024,    0,      0);
    run_one("bnd_real",   256,   106, 7,  256,  106,    874);
    run_one("bnd_diag",   256,   107, 6,  256, -106,    874);
    run_one("zero",         0,     0, 7,    0,    0,   1024);
    run_one("k2_axis",      0,   500, 2,  500,    0,    524);
    run_one("k3_diag",   -300,   300, 3,  424,    0,    600);
    run_one("k5_diag",   -300,  -300, 0,  424,    0,    600);
    run_one("k7_diag",    300,  -300, 5,  424,    0,    600);
    run_one("sat_axis", -524288,   0, 1, 524287,  0, 523263);
    run_one("sat_diag", -524288, -524288, 0, 524287, 0, 523263);

    // Back-to-back stream of 5 with a 4-cycle downstream stall after the first result.
    sent = 0; recv = 0; stall = 0;
    for (int c = 0; c < 30 && recv < 5; c++) begin
      out_ready = !(recv >= 1 && stall < 4);
      in_valid  = (sent < 5);
      y_real    = 20'(100 * (sent + 1));
      y_imag    = '0;
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (stall == 0) begin
          hold_re = res_real;
          hold_s  = s_hat;
        end else begin
          chk("stall_hold_res", res_real, hold_re);
          chk("stall_hold_s_hat", s_hat, hold_s);
        end
        stall++;
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        chk("stream_res_real", res_real, 100 * (recv + 1));
        chk("stream_s_hat", s_hat, 7);
        $display("txn stream result %0d res_real=%0d", recv, res_real);
        recv++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", recv, 5);
    chk("stream_stall_cycles", stall, 4);
    chk("stream_drained", out_valid, 0);

    // Reset mid-stream with 3 samples in flight (output held by backpressure).
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      y_real   = 20'(500 + i);
      y_imag   = '0;
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    in_valid = 1'b1;
    y_real = 20'(777);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s_hat", s_hat, 0);
    chk("rst_res_real", res_real, 0);
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_no_emit", out_valid, 0);
    end
    $display("txn reset mid-stream done");
    run_one("post_rst", 300, -300, 5, 424, 0, 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
